// File: rtl/uca_queue_pkg.sv
// uca_queue_pkg: shared solver literal type, helpers and queue state encoding
package uca_queue_pkg;
  localparam int LIT_W = 8;
  typedef logic [LIT_W-1:0] lit_t;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, CONFLICT} q_state_t;
  function automatic logic [LIT_W-2:0] lit_var(lit_t l);
    return l[LIT_W-2:0];
  endfunction
  function automatic logic lit_pol(lit_t l);
    return l[LIT_W-1];
  endfunction
endpackage

// File: rtl/uca_queue_if.sv
// uca_queue_if: lookup-side input, consumer handshake and status of the unit-literal queue
interface uca_queue_if #(parameter int DEPTH = 16);
  import uca_queue_pkg::*;
  lit_t mem2uca;
  logic mem2uca_valid;
  logic mem2uca_done;
  logic flush;
  lit_t uca_lit;
  logic uca_valid;
  logic uca_ready;
  logic conflict;
  logic overflow;
  logic batch_done;
  logic [$clog2(DEPTH):0] count;
  modport master(output mem2uca, mem2uca_valid, mem2uca_done, flush, uca_ready,
                 input uca_lit, uca_valid, conflict, overflow, batch_done, count);
  modport slave(input mem2uca, mem2uca_valid, mem2uca_done, flush, uca_ready,
                output uca_lit, uca_valid, conflict, overflow, batch_done, count);
endinterface

// File: rtl/uca_cam_match.sv
// uca_cam_match: compares one literal against all occupied entries for duplicate or complement
module uca_cam_match
  import uca_queue_pkg::*;
#(parameter int DEPTH = 16) (
  input  logic [DEPTH-1:0] occ,
  input  lit_t             ent [DEPTH],
  input  lit_t             lit,
  output logic             dup,
  output logic             comp
);
  always_comb begin
    dup = 1'b0;
    comp = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dup |= occ[i] && ent[i] == lit;
      comp |= occ[i] && lit_var(ent[i]) == lit_var(lit) && lit_pol(ent[i]) != lit_pol(lit);
    end
  end
endmodule

// File: rtl/uca_queue.sv
// uca_queue: deduplicating circular queue of implied unit literals with conflict detection
module uca_queue
  import uca_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LIT_W = uca_queue_pkg::LIT_W
) (
  input logic       clk,
  input logic       rst,
  uca_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  lit_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic [DEPTH-1:0] occ;
  logic ovf, dup, comp, in_ok, pop, push, full, done_in, bdone;
  q_state_t state, nxt;
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    assign occ[i] = {1'b0, AW'(i) - rd_ptr} < cnt;
  end
  uca_cam_match #(.DEPTH(DEPTH)) u_cam (
    .occ (occ),
    .ent (mem),
    .lit (q.mem2uca),
    .dup (dup),
    .comp(comp)
  );
  assign full = cnt == (AW+1)'(DEPTH);
  assign q.uca_valid = cnt != '0 && state != CONFLICT;
  assign q.uca_lit = mem[rd_ptr];
  assign q.count = cnt;
  assign q.conflict = state == CONFLICT;
  assign q.overflow = ovf;
  assign q.batch_done = bdone;
  assign in_ok = q.mem2uca_valid && q.mem2uca[LIT_W-2:0] != '0 && state != CONFLICT && !q.flush;
  assign pop = q.uca_valid && q.uca_ready && !q.flush;
  assign push = in_ok && !dup && !comp && (!full || pop);
  assign done_in = q.mem2uca_done && state != CONFLICT;
  assign bdone = state == DRAIN && cnt == '0 && !push;
  always_comb begin
    nxt = state;
    if (in_ok && comp) nxt = CONFLICT;
    else if (state == IDLE && done_in) nxt = DRAIN;
    else if (state == IDLE && push) nxt = COLLECT;
    else if (state == COLLECT && done_in) nxt = DRAIN;
    else if (bdone) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      state <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      ovf <= ovf | (in_ok && !dup && !comp && full && !pop);
      state <= nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q.mem2uca;
  end
endmodule

// File: doc/uca_queue.md
UCA_QUEUE -- requirements
Module: uca_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue entries (power of two, >=2).
REQ-002 Parameter LIT_W, default 8, literal width taken from the shared package.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 mem2uca  in  lit_t  implied unit literal from the lookup stage.
REQ-006 mem2uca_valid  in  1  mem2uca is valid this cycle.
REQ-007 mem2uca_done  in  1  lookup batch finished; may coincide with mem2uca_valid.
REQ-008 flush  in  1  discard all contents and state (backtrack / change_eng).
REQ-009 uca_lit  out  lit_t  head literal toward the propagation engine.
REQ-010 uca_valid  out  1  uca_lit is valid.
REQ-011 uca_ready  in  1  consumer pops the head when uca_valid && uca_ready.
REQ-012 conflict  out  1  sticky; complementary literal detected.
REQ-013 overflow  out  1  sticky; a literal was dropped because the queue was full.
REQ-014 batch_done  out  1  one-cycle pulse; batch fully drained.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 lit_t: MSB = polarity, low LIT_W-1 bits = variable index; variable 0 is null, and a valid null literal is ignored.
REQ-017 Two literals are complementary when their variable indices are equal and their polarities differ.
REQ-018 Each valid non-null input is compared against all occupied entries, including a head popped in the same cycle.
REQ-019 Identical match: literal dropped, no state change.
REQ-020 Complementary match: literal dropped; conflict set next cycle; FSM enters CONFLICT.
REQ-021 No match and (count<DEPTH or pop this cycle): literal written at wr_ptr.
REQ-022 No match, count==DEPTH and no pop: literal dropped; overflow set.
REQ-023 The queue is circular; rd_ptr and wr_ptr wrap from DEPTH-1 to 0.
REQ-024 count += push, -= pop; a simultaneous push and pop leaves count unchanged.
REQ-025 uca_lit is driven from the registered head entry (no fall-through).
REQ-026 A literal pushed at edge N is visible on uca_lit/uca_valid no earlier than after edge N.
REQ-027 uca_valid = (count!=0) && state!=CONFLICT.
REQ-028 uca_lit holds stable while uca_valid && !uca_ready.
REQ-029 FSM states: IDLE, COLLECT, DRAIN, CONFLICT.
REQ-030 IDLE->COLLECT on an accepted push without done; IDLE->DRAIN on done (the same-cycle literal is processed first).
REQ-031 COLLECT->DRAIN on mem2uca_done.
REQ-032 DRAIN->IDLE when count reaches 0 with no push pending; batch_done pulses that cycle.
REQ-033 Done in IDLE with an empty queue pulses batch_done one cycle later.
REQ-034 Inputs arriving in DRAIN are still processed per REQ-018..022.
REQ-035 CONFLICT ignores inputs and pops; the state is left only by flush or rst.
REQ-036 flush has priority over push and pop in the same cycle.
REQ-037 flush clears pointers, count, conflict and overflow, and returns to IDLE.
REQ-038 uca_valid=0 in the cycle after flush.

Reset
REQ-039 rst clears state to IDLE, rd_ptr=0, wr_ptr=0 and count=0.
REQ-040 rst drives conflict=0, overflow=0, batch_done=0 and uca_valid=0.
REQ-041 rst mid-batch discards all entries; storage array contents need not be reset.
REQ-042 rst overrides flush and all inputs.

Structure
REQ-043 lit_t, LIT_W, the lit_var/lit_pol helpers and the queue state enum live in the shared solver package.
REQ-044 The match search is one sub-module, uca_cam_match: occupied-mask plus literal in; dup and comp flags out.

Verification
REQ-045 Push 0x03, 0x05, 0x07, then pulse done, uca_ready=1 -> uca_lit 0x03, 0x05, 0x07 in order; batch_done pulses once; count ends at 0.
REQ-046 Push 0x05 twice -> count=1; a single 0x05 is delivered.
REQ-047 Push 0x05 then 0x85 -> conflict=1 next cycle; uca_valid=0; a subsequent flush clears conflict and sets count=0.
REQ-048 DEPTH=16, uca_ready=0, 17 distinct literals -> count=16, overflow=1; the 17th literal is never delivered.
REQ-049 Full queue with push and pop in the same cycle -> push accepted; count stays 16; pointers wrap correctly over 40 cycles.
REQ-050 mem2uca_done alone in IDLE -> batch_done pulses in the next cycle.
REQ-051 flush in the same cycle as a push -> count=0 and uca_valid=0 next cycle.
